// File: rtl/diff_core_pkg.sv
// Shared types for the multiplier / partial-sum datapath.
// Mode encoding matches the multiplier's mode port.
package diff_core_pkg;

  typedef enum logic {MODE_8B = 1'b0, MODE_4B = 1'b1} mul_mode_e;

  localparam int PSUM_ACC_W = 24;

  typedef enum logic {PS_IDLE = 1'b0, PS_ACC = 1'b1} psum_state_e;

endpackage

// File: rtl/sat_add.sv
// Unsigned W-bit adder that clamps to all-ones on carry out and reports it.
module sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[W];
  assign sum  = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates multiplier products into one (8-bit mode) or two (packed 4x4 mode)
// saturating lane sums per last-delimited group and holds the result for the consumer.
module psum_accumulator
  import diff_core_pkg::*;
#(
  parameter int ACC_W = PSUM_ACC_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [ACC_W-1:0] out_lane1,
  output logic [ACC_W-1:0] out_lane0,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             state
);

  // Handshake: a transfer happens on a cycle where valid && ready. A producer
  // holds valid and its payload until that cycle; ready never depends on valid.
  // The only stall source is a held result that the consumer has not taken.

  psum_state_e      state_q;
  mul_mode_e        mode_q;
  logic [ACC_W-1:0] lane0_q;
  logic [ACC_W-1:0] lane1_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;

  logic             accept;
  logic             first;
  mul_mode_e        grp_mode;
  logic [ACC_W-1:0] a0, b0, a1, b1;
  logic [ACC_W-1:0] sum0, sum1;
  logic             ovf0, ovf1;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_next;

  assign in_ready = !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign first    = (state_q == PS_IDLE);
  assign grp_mode = first ? mul_mode_e'(in_mode) : mode_q;
  assign state    = logic'(state_q);

  // The first beat of a group adds to zero so stale sums never leak in.
  assign a0 = first ? '0 : lane0_q;
  assign a1 = first ? '0 : lane1_q;
  assign b0 = (grp_mode == MODE_4B) ? ACC_W'(in_prod[7:0]) : ACC_W'(in_prod);
  assign b1 = (grp_mode == MODE_4B) ? ACC_W'(in_prod[15:8]) : '0;

  sat_add #(.W(ACC_W)) u_lane0 (.a(a0), .b(b0), .sum(sum0), .ovf(ovf0));
  sat_add #(.W(ACC_W)) u_lane1 (.a(a1), .b(b1), .sum(sum1), .ovf(ovf1));

  assign cnt_next = first ? CNT_W'(1) :
                    (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign sat_next = (first ? 1'b0 : sat_q) | ovf0 | ovf1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PS_IDLE;
      mode_q    <= MODE_8B;
      lane0_q   <= '0;
      lane1_q   <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_lane1 <= '0;
      out_lane0 <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (in_last) begin
          // Closing beat: publish and clear so a new group can start next cycle.
          out_valid <= 1'b1;
          out_mode  <= logic'(grp_mode);
          out_lane1 <= sum1;
          out_lane0 <= sum0;
          out_count <= cnt_next;
          out_sat   <= sat_next;
          state_q   <= PS_IDLE;
          lane0_q   <= '0;
          lane1_q   <= '0;
          cnt_q     <= '0;
          sat_q     <= 1'b0;
        end else begin
          state_q   <= PS_ACC;
          mode_q    <= grp_mode;
          lane0_q   <= sum0;
          lane1_q   <= sum1;
          cnt_q     <= cnt_next;
          sat_q     <= sat_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: per-cycle vector table plus
// hand-written saturation, back-pressure and reset sequences.
module tb_psum_accumulator;

  localparam int ACC_W = 24;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [15:0]      in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [ACC_W-1:0] out_lane1;
  logic [ACC_W-1:0] out_lane0;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;
  logic             state;

  int checks = 0;
  int errors = 0;

  logic [ACC_W-1:0] exp_q[$];

  psum_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_lane1(out_lane1), .out_lane0(out_lane0), .out_count(out_count),
    .out_sat(out_sat), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        mode;
    logic [15:0] prod;
    logic        last;
    logic        ordy;
    logic        e_valid;
    logic        e_mode;
    logic [23:0] e_l1;
    logic [23:0] e_l0;
    logic [15:0] e_cnt;
    logic        e_sat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: present one beat, clock it in, land #1 after the edge
  task automatic step(input logic v, input logic m, input logic [15:0] p,
                      input logic l, input logic ordy);
    in_valid  = v;
    in_mode   = m;
    in_prod   = p;
    in_last   = l;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: compares a published result against the oldest expected lane0
  task automatic expect_result(input logic m, input logic [23:0] l1,
                               input logic [15:0] cnt, input logic sat);
    logic [ACC_W-1:0] e0;
    chk("res_valid", 64'(out_valid), 64'(1'b1));
    if (exp_q.size() == 0) begin
      chk("res_queue_empty", 64'(exp_q.size()), 64'(1));
    end else begin
      e0 = exp_q.pop_front();
      chk("res_lane0", 64'(out_lane0), 64'(e0));
    end
    chk("res_lane1", 64'(out_lane1), 64'(l1));
    chk("res_count", 64'(out_count), 64'(cnt));
    chk("res_sat", 64'(out_sat), 64'(sat));
    chk("res_mode", 64'(out_mode), 64'(m));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_mode = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b1;

    //              v  m  prod     l  rdy  ev em  lane1     lane0     cnt  sat
    tbl[0]  = '{1'b1, 1'b0, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0,  24'h0,     16'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'h0200, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0,  24'h0,     16'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0,  24'h000303, 16'd3, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 16'h1002, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0,  24'h0,     16'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'h1002, 1'b1, 1'b1, 1'b1, 1'b1, 24'h20, 24'h04,    16'd2, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0,  24'h0,     16'd0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 16'hFF01, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFF, 24'h01,    16'd1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 16'h0102, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0,  24'h0,     16'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0,  24'h0,     16'd0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 16'h0304, 1'b1, 1'b1, 1'b1, 1'b1, 24'h04, 24'h06,    16'd2, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0,  24'h1234,  16'd1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_lane0", 64'(out_lane0), 64'(0));
    chk("rst_count", 64'(out_count), 64'(0));
    chk("rst_state", 64'(state), 64'(0));
    rst = 1'b0;
    #2;

    // table-driven vectors, including a release-and-close in the same cycle (row 10)
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].valid, tbl[i].mode, tbl[i].prod, tbl[i].last, tbl[i].ordy);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_lane0", i), 64'(out_lane0), 64'(tbl[i].e_l0));
        chk($sformatf("tbl%0d_lane1", i), 64'(out_lane1), 64'(tbl[i].e_l1));
        chk($sformatf("tbl%0d_count", i), 64'(out_count), 64'(tbl[i].e_cnt));
        chk($sformatf("tbl%0d_sat", i), 64'(out_sat), 64'(tbl[i].e_sat));
        chk($sformatf("tbl%0d_mode", i), 64'(out_mode), 64'(tbl[i].e_mode));
      end
    end

    // saturation: 257 x 0xFFFF overflows a 24-bit lane on the last beat
    for (int i = 0; i < 257; i++) begin
      step(1'b1, 1'b0, 16'hFFFF, (i == 256), 1'b1);
      if (i == 255) chk("sat_no_early_valid", 64'(out_valid), 64'(0));
    end
    exp_q.push_back(24'hFFFFFF);
    expect_result(1'b0, 24'h0, 16'd257, 1'b1);
    step(1'b1, 1'b0, 16'h0007, 1'b1, 1'b1);
    exp_q.push_back(24'h000007);
    expect_result(1'b0, 24'h0, 16'd1, 1'b0);

    // back-pressure: result held, input stalled, outputs stable
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("bp_drain", 64'(out_valid), 64'(0));
    step(1'b1, 1'b0, 16'h0009, 1'b1, 1'b0);
    exp_q.push_back(24'h000009);
    expect_result(1'b0, 24'h0, 16'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b0);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_lane0", 64'(out_lane0), 64'(24'h9));
      chk("bp_count", 64'(out_count), 64'(1));
    end
    in_valid = 1'b1; in_mode = 1'b0; in_prod = 16'h0005; in_last = 1'b1; out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'(1));
    step(1'b1, 1'b0, 16'h0005, 1'b1, 1'b1);
    exp_q.push_back(24'h000005);
    expect_result(1'b0, 24'h0, 16'd1, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("bp_taken", 64'(out_valid), 64'(0));

    // reset mid-group discards partial sums and clears held fields
    step(1'b1, 1'b0, 16'h0010, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0010, 1'b0, 1'b1);
    chk("mid_state_acc", 64'(state), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_lane0", 64'(out_lane0), 64'(0));
    chk("mid_rst_lane1", 64'(out_lane1), 64'(0));
    chk("mid_rst_count", 64'(out_count), 64'(0));
    chk("mid_rst_sat", 64'(out_sat), 64'(0));
    chk("mid_rst_state", 64'(state), 64'(0));
    chk("mid_rst_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 16'h0001, 1'b1, 1'b1);
    exp_q.push_back(24'h000001);
    expect_result(1'b0, 24'h0, 16'd1, 1'b0);

    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
